// File: rtl/lcd_pkg.sv
// Shared definitions for the HD44780 write-only controller: state encoding,
// init ROM contents, the commands that need a long post-strobe wait, and timing helpers.
package lcd_pkg;

    typedef enum logic [2:0] {
        ST_PWRUP     = 3'd0,
        ST_INIT_LOAD = 3'd1,
        ST_IDLE      = 3'd2,
        ST_SETUP     = 3'd3,
        ST_EN_HI     = 3'd4,
        ST_HOLD      = 3'd5,
        ST_WAIT      = 3'd6
    } lcd_state_e;

    localparam int INIT_LEN = 4;

    localparam logic [7:0] INIT_CMD_0 = 8'h38;   // 8-bit bus, 2 lines, 5x8 font
    localparam logic [7:0] INIT_CMD_1 = 8'h0C;   // display on, cursor off
    localparam logic [7:0] INIT_CMD_2 = 8'h01;   // clear
    localparam logic [7:0] INIT_CMD_3 = 8'h06;   // entry mode: increment, no shift

    localparam logic [7:0] CMD_CLEAR = 8'h01;
    localparam logic [7:0] CMD_HOME  = 8'h02;

    function automatic logic [7:0] init_rom(input logic [1:0] idx);
        logic [7:0] b;
        case (idx)
            2'd0:    b = INIT_CMD_0;
            2'd1:    b = INIT_CMD_1;
            2'd2:    b = INIT_CMD_2;
            default: b = INIT_CMD_3;
        endcase
        return b;
    endfunction

    // A zero-length phase would make the counter wrap, so it is stretched to one cycle.
    function automatic int unsigned t_eff(input int unsigned t);
        return (t == 0) ? 1 : t;
    endfunction

    function automatic int unsigned max2(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/lcd_ctrl.sv
// HD44780 write sequencer: power-up delay, fixed init sequence, then one
// strobed byte per request with a command-dependent post-strobe wait.
module lcd_ctrl
    import lcd_pkg::*;
#(
    parameter int unsigned T_SETUP    = 2,
    parameter int unsigned T_EN_HIGH  = 25,
    parameter int unsigned T_HOLD     = 2,
    parameter int unsigned T_CMD_WAIT = 2000,
    parameter int unsigned T_CLR_WAIT = 82000,
    parameter int unsigned T_PWRUP    = 750000
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       req_valid_i,
    input  logic       req_rs_i,
    input  logic [7:0] req_data_i,
    output logic       req_ready_o,
    output logic       init_done_o,
    output logic       lcd_en_o,
    output logic       lcd_rs_o,
    output logic       lcd_rw_o,
    output logic [7:0] lcd_data_o,
    output logic       lcd_on_o
);

    localparam int unsigned TE_SETUP = t_eff(T_SETUP);
    localparam int unsigned TE_EN    = t_eff(T_EN_HIGH);
    localparam int unsigned TE_HOLD  = t_eff(T_HOLD);
    localparam int unsigned TE_CMD   = t_eff(T_CMD_WAIT);
    localparam int unsigned TE_CLR   = t_eff(T_CLR_WAIT);
    localparam int unsigned TE_PWRUP = t_eff(T_PWRUP);

    localparam int unsigned T_MAX = max2(max2(max2(TE_SETUP, TE_EN), max2(TE_HOLD, TE_CMD)),
                                         max2(TE_CLR, TE_PWRUP));
    localparam int CW = $clog2(T_MAX) + 1;

    localparam logic [CW-1:0] LD_SETUP = CW'(TE_SETUP - 1);
    localparam logic [CW-1:0] LD_EN    = CW'(TE_EN - 1);
    localparam logic [CW-1:0] LD_HOLD  = CW'(TE_HOLD - 1);
    localparam logic [CW-1:0] LD_CMD   = CW'(TE_CMD - 1);
    localparam logic [CW-1:0] LD_CLR   = CW'(TE_CLR - 1);
    localparam logic [CW-1:0] LD_PWRUP = CW'(TE_PWRUP - 1);

    localparam logic [2:0] PWRUP     = ST_PWRUP;
    localparam logic [2:0] INIT_LOAD = ST_INIT_LOAD;
    localparam logic [2:0] IDLE      = ST_IDLE;
    localparam logic [2:0] SETUP     = ST_SETUP;
    localparam logic [2:0] EN_HI     = ST_EN_HI;
    localparam logic [2:0] HOLD      = ST_HOLD;
    localparam logic [2:0] WAIT      = ST_WAIT;

    localparam logic [1:0] INIT_LAST = 2'(INIT_LEN - 1);

    logic [2:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    idx_q, idx_d;
    logic          en_q, en_d;
    logic          rs_q, rs_d;
    logic [7:0]    data_q, data_d;
    logic          on_q;
    logic          ready_q, ready_d;
    logic          done_q, done_d;

    logic cnt_zero;
    logic accept;
    logic long_wait;

    assign cnt_zero  = (cnt_q == '0);
    assign accept    = (state_q == IDLE) && ready_q && req_valid_i;
    assign long_wait = !rs_q && ((data_q == CMD_CLEAR) || (data_q == CMD_HOME));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_zero ? cnt_q : (cnt_q - CW'(1));
        idx_d   = idx_q;
        en_d    = en_q;
        rs_d    = rs_q;
        data_d  = data_q;
        done_d  = done_q;

        case (state_q)
            PWRUP: begin
                // Reset leaves the counter at zero; the first clock after release
                // marks state entry and loads the power-up delay.
                if (!on_q) begin
                    cnt_d = LD_PWRUP;
                end else if (cnt_zero) begin
                    state_d = INIT_LOAD;
                    idx_d   = 2'd0;
                end
            end
            INIT_LOAD: begin
                rs_d    = 1'b0;
                data_d  = init_rom(idx_q);
                state_d = SETUP;
                cnt_d   = LD_SETUP;
            end
            IDLE: begin
                if (accept) begin
                    rs_d    = req_rs_i;
                    data_d  = req_data_i;
                    state_d = SETUP;
                    cnt_d   = LD_SETUP;
                end
            end
            SETUP: begin
                if (cnt_zero) begin
                    state_d = EN_HI;
                    cnt_d   = LD_EN;
                    en_d    = 1'b1;
                end
            end
            EN_HI: begin
                if (cnt_zero) begin
                    state_d = HOLD;
                    cnt_d   = LD_HOLD;
                    en_d    = 1'b0;
                end
            end
            HOLD: begin
                if (cnt_zero) begin
                    state_d = WAIT;
                    cnt_d   = long_wait ? LD_CLR : LD_CMD;
                end
            end
            WAIT: begin
                if (cnt_zero) begin
                    if (done_q) begin
                        state_d = IDLE;
                    end else if (idx_q == INIT_LAST) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = INIT_LOAD;
                        idx_d   = idx_q + 2'd1;
                    end
                end
            end
            default: begin
                state_d = PWRUP;
                cnt_d   = '0;
                en_d    = 1'b0;
            end
        endcase

        // Registered ready follows the next state so it drops right after an accept.
        ready_d = (state_d == IDLE) && done_d;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= PWRUP;
            cnt_q   <= '0;
            idx_q   <= 2'd0;
            en_q    <= 1'b0;
            rs_q    <= 1'b0;
            data_q  <= 8'h00;
            on_q    <= 1'b0;
            ready_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            en_q    <= en_d;
            rs_q    <= rs_d;
            data_q  <= data_d;
            on_q    <= 1'b1;
            ready_q <= ready_d;
            done_q  <= done_d;
        end
    end

    assign req_ready_o = ready_q;
    assign init_done_o = done_q;
    assign lcd_en_o    = en_q;
    assign lcd_rs_o    = rs_q;
    assign lcd_rw_o    = 1'b0;
    assign lcd_data_o  = data_q;
    assign lcd_on_o    = on_q;

endmodule

// File: tb/tb_lcd_ctrl.sv
// Bench for lcd_ctrl: records a per-cycle trace of the LCD bus and checks it
// against the expected byte stream and timing arithmetic.
module tb_lcd_ctrl;

    localparam int TSU  = 2;
    localparam int TEN  = 3;
    localparam int THO  = 2;
    localparam int TCMD = 5;
    localparam int TCLR = 9;
    localparam int TPW  = 10;
    localparam int MAXT = 8192;
    localparam int NINIT = 4;

    logic       clk = 1'b0;
    logic       rst_ni = 1'b1;
    logic       req_valid_i = 1'b0;
    logic       req_rs_i = 1'b0;
    logic [7:0] req_data_i = 8'h00;
    logic       req_ready_o, init_done_o, lcd_en_o, lcd_rs_o, lcd_rw_o, lcd_on_o;
    logic [7:0] lcd_data_o;

    lcd_ctrl #(
        .T_SETUP(TSU), .T_EN_HIGH(TEN), .T_HOLD(THO),
        .T_CMD_WAIT(TCMD), .T_CLR_WAIT(TCLR), .T_PWRUP(TPW)
    ) dut (
        .clk_i(clk), .rst_ni(rst_ni),
        .req_valid_i(req_valid_i), .req_rs_i(req_rs_i), .req_data_i(req_data_i),
        .req_ready_o(req_ready_o), .init_done_o(init_done_o),
        .lcd_en_o(lcd_en_o), .lcd_rs_o(lcd_rs_o), .lcd_rw_o(lcd_rw_o),
        .lcd_data_o(lcd_data_o), .lcd_on_o(lcd_on_o)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err = 0;

    bit       tr_en   [MAXT];
    bit       tr_rdy  [MAXT];
    bit       tr_done [MAXT];
    bit       tr_vld  [MAXT];
    bit       tr_rw   [MAXT];
    bit [8:0] tr_byte [MAXT];
    int       n = 0;

    bit [8:0] exp_q[$];

    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (n < MAXT) begin
                tr_en[n]   = lcd_en_o;
                tr_rdy[n]  = req_ready_o;
                tr_done[n] = init_done_o;
                tr_vld[n]  = req_valid_i;
                tr_rw[n]   = lcd_rw_o;
                tr_byte[n] = {lcd_rs_o, lcd_data_o};
                n++;
            end
        end
    end

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    function automatic int wait_of(input bit [8:0] b);
        return (!b[8] && (b[7:0] == 8'h01 || b[7:0] == 8'h02)) ? TCLR : TCMD;
    endfunction

    task automatic push_init();
        exp_q.delete();
        exp_q.push_back({1'b0, 8'h38});
        exp_q.push_back({1'b0, 8'h0C});
        exp_q.push_back({1'b0, 8'h01});
        exp_q.push_back({1'b0, 8'h06});
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic send(input bit rs, input bit [7:0] d, input bit keep);
        bit got = 0;
        req_rs_i = rs;
        req_data_i = d;
        req_valid_i = 1'b1;
        for (int i = 0; i < 400; i++) begin
            if (req_ready_o) begin
                got = 1;
                break;
            end
            @(negedge clk);
        end
        check("accept timeout", int'(got), 1);
        exp_q.push_back({rs, d});
        @(negedge clk);
        if (!keep) req_valid_i = 1'b0;
    endtask

    task automatic drain();
        bit got = 0;
        for (int i = 0; i < 400; i++) begin
            if (req_ready_o) begin
                got = 1;
                break;
            end
            @(negedge clk);
        end
        check("drain timeout", int'(got), 1);
        @(negedge clk);
        #3;
    endtask

    task automatic analyse(input string ph, input int t0, input int t1);
        int ps[$];
        int pe[$];
        int acc[$];
        int np;
        int bad;
        for (int t = t0; t < t1; t++) begin
            if (tr_en[t] && (t == t0 || !tr_en[t-1])) ps.push_back(t);
            if (tr_en[t] && (t == t1 - 1 || !tr_en[t+1])) pe.push_back(t);
            if (tr_vld[t] && tr_rdy[t]) acc.push_back(t);
        end
        check({ph, " pulse count"}, ps.size(), exp_q.size());
        np = (ps.size() < exp_q.size()) ? ps.size() : exp_q.size();
        if (pe.size() < np) np = pe.size();
        for (int k = 0; k < np; k++) begin
            bit [8:0] b = exp_q[k];
            int w = wait_of(b);
            int stable = 1;
            int r = -1;
            check($sformatf("%s pulse%0d width", ph, k), pe[k] - ps[k] + 1, TEN);
            check($sformatf("%s pulse%0d byte", ph, k), int'(tr_byte[ps[k]]), int'(b));
            for (int t = ps[k] - TSU; t <= pe[k] + THO; t++)
                if (t < t0 || t >= t1 || tr_byte[t] !== b) stable = 0;
            check($sformatf("%s pulse%0d setup/hold", ph, k), stable, 1);
            if (k < NINIT - 1) begin
                if (k + 1 < ps.size())
                    check($sformatf("%s init gap%0d", ph, k), ps[k+1] - pe[k] - 1, THO + w + 1 + TSU);
            end else begin
                for (int t = pe[k] + 1; t < t1; t++)
                    if (tr_rdy[t]) begin
                        r = t;
                        break;
                    end
                check($sformatf("%s ready gap%0d", ph, k), r - pe[k] - 1, THO + w);
            end
        end
        check({ph, " accept count"}, acc.size(), exp_q.size() - NINIT);
        for (int i = 0; i < acc.size(); i++) begin
            bit held = 1;
            if (NINIT + i < ps.size())
                check($sformatf("%s accept%0d to EN", ph, i), ps[NINIT+i] - acc[i], 1 + TSU);
            if (i > 0) begin
                for (int t = acc[i-1]; t <= acc[i]; t++) if (!tr_vld[t]) held = 0;
                if (held)
                    check($sformatf("%s latency%0d", ph, i), acc[i] - acc[i-1],
                          1 + TSU + TEN + THO + wait_of(exp_q[NINIT+i-1]));
            end
        end
        bad = 0;
        for (int t = t0; t < t1; t++) begin
            if (tr_rdy[t] && !tr_done[t]) bad++;
            if (tr_rw[t]) bad++;
            if (tr_done[t] && (pe.size() < NINIT || t <= pe[NINIT-1])) bad++;
        end
        check({ph, " ready/done/rw sanity"}, bad, 0);
    endtask

    initial begin
        int t0;
        bit seen;

        // Phase 1: reset values, early request, init, directed and random traffic.
        #3 rst_ni = 1'b0;
        repeat (3) @(negedge clk);
        check("rst en", int'(lcd_en_o), 0);
        check("rst rs", int'(lcd_rs_o), 0);
        check("rst rw", int'(lcd_rw_o), 0);
        check("rst data", int'(lcd_data_o), 0);
        check("rst on", int'(lcd_on_o), 0);
        check("rst ready", int'(req_ready_o), 0);
        check("rst done", int'(init_done_o), 0);

        push_init();
        req_valid_i = 1'b1;
        req_rs_i = 1'b1;
        req_data_i = 8'hA5;
        rst_ni = 1'b1;
        t0 = n;
        @(negedge clk);
        check("on after release", int'(lcd_on_o), 1);
        send(1'b1, 8'hA5, 1'b0);

        send(1'b1, 8'h41, 1'b0);
        drain();
        @(negedge clk);
        send(1'b0, 8'h01, 1'b1);
        send(1'b1, 8'h42, 1'b0);
        drain();
        @(negedge clk);
        send(1'b0, 8'h80, 1'b1);
        send(1'b0, 8'h80, 1'b0);

        for (int i = 0; i < 24; i++) begin
            bit rs = 1'($urandom_range(0, 1));
            bit [7:0] d = 8'($urandom_range(0, 255));
            bit keep = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 3) == 0) begin
                rs = 1'b0;
                d = 8'($urandom_range(0, 2));
            end
            send(rs, d, keep);
            if (!keep) repeat ($urandom_range(0, 3)) @(negedge clk);
        end
        req_valid_i = 1'b0;
        drain();
        analyse("p1", t0, n);

        // Phase 2: reset in the middle of the enable pulse.
        @(negedge clk);
        send(1'b0, 8'h80, 1'b0);
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            if (lcd_en_o) begin
                seen = 1;
                break;
            end
            @(negedge clk);
        end
        check("EN seen before mid-pulse reset", int'(seen), 1);
        #1 rst_ni = 1'b0;
        #1;
        check("midrst en", int'(lcd_en_o), 0);
        check("midrst rs", int'(lcd_rs_o), 0);
        check("midrst data", int'(lcd_data_o), 0);
        check("midrst rw", int'(lcd_rw_o), 0);
        check("midrst on", int'(lcd_on_o), 0);
        check("midrst ready", int'(req_ready_o), 0);
        check("midrst done", int'(init_done_o), 0);
        repeat (3) @(negedge clk);
        push_init();
        rst_ni = 1'b1;
        t0 = n;
        @(negedge clk);
        check("on after re-release", int'(lcd_on_o), 1);
        send(1'b1, 8'h33, 1'b0);
        send(1'b0, 8'h02, 1'b0);
        drain();
        analyse("p2", t0, n);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/lcd_ctrl.md
LCD_CTRL -- requirements
Module: lcd_ctrl

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- T_SETUP, 2, cycles that RS/RW/DATA are stable before EN rises.
- T_EN_HIGH, 25, cycles EN is held high.
- T_HOLD, 2, cycles RS/DATA are held after EN falls.
- T_CMD_WAIT, 2000, post-strobe wait for a normal command or data byte.
- T_CLR_WAIT, 82000, post-strobe wait for a clear or home command.
- T_PWRUP, 750000, wait after reset release before the init sequence.
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
- clk_i, in, 1, system clock.
- rst_ni, in, 1, asynchronous active-low reset.
- req_valid_i, in, 1, requester has a byte.
- req_rs_i, in, 1, 0 = command, 1 = data.
- req_data_i, in, 8, byte to write.
- req_ready_o, out, 1, controller can accept.
- init_done_o, out, 1, init sequence complete.
- lcd_en_o, out, 1, HD44780 E.
- lcd_rs_o, out, 1, HD44780 RS.
- lcd_rw_o, out, 1, HD44780 RW; always 0 (write-only).
- lcd_data_o, out, 8, HD44780 DB7..DB0.
- lcd_on_o, out, 1, panel power; 1 whenever out of reset.

Function
REQ-003 FSM states SHALL be: PWRUP, INIT_LOAD, IDLE, SETUP, EN_HI, HOLD, WAIT.
REQ-004 PWRUP SHALL count T_PWRUP cycles, then go to INIT_LOAD with init index 0.
REQ-005 The init ROM SHALL hold 0x38, 0x0C, 0x01, 0x06, each with rs=0.
- INIT_LOAD latches the ROM entry at the current index, then goes to SETUP.
- After the WAIT that follows entry 3, init_done_o rises and the FSM enters IDLE.
REQ-006 req_ready_o SHALL be 1 only in IDLE with init_done_o=1.
- A transfer occurs on the clock edge where req_valid_i & req_ready_o.
- On that edge, req_rs_i and req_data_i are latched and the FSM goes to SETUP.
- req_ready_o drops in the next cycle.
REQ-007 Strobe timing SHALL be:
- SETUP holds lcd_en_o=0 for T_SETUP cycles.
- EN_HI holds lcd_en_o=1 for exactly T_EN_HIGH cycles.
- HOLD holds lcd_en_o=0 for T_HOLD cycles.
- lcd_rs_o and lcd_data_o stay constant from entry to SETUP through the end of HOLD.
REQ-008 WAIT duration SHALL be T_CLR_WAIT when the latched byte has rs=0 and data 0x01 or 0x02; otherwise it SHALL be T_CMD_WAIT.
REQ-009 WAIT exit SHALL go to INIT_LOAD (next index) during init, else to IDLE.
REQ-010 Accept-to-accept latency SHALL be 1+T_SETUP+T_EN_HIGH+T_HOLD+wait cycles.
- Back-to-back valid is accepted on the first IDLE cycle.
REQ-011 req_valid_i during PWRUP or init SHALL be ignored, with no latching, until ready.
REQ-012 One down-counter SHALL serve all states.
- Width is $clog2(max of all T_* parameters)+1.
- The counter is loaded with T-1 on state entry and advances on reaching zero.
- A T_* value of 0 SHALL be treated as 1.
REQ-013 Outputs SHALL be registered; lcd_en_o SHALL be glitch-free.

Reset
REQ-014 rst_ni low SHALL asynchronously force the following values:
- state = PWRUP, counter and init index = 0.
- lcd_en_o = 0, lcd_rs_o = 0, lcd_rw_o = 0, lcd_data_o = 0x00.
- lcd_on_o = 0, req_ready_o = 0, init_done_o = 0.
REQ-015 Reset asserted mid-strobe SHALL drop lcd_en_o immediately.
- After release, the full power-up and init sequence reruns.
- No partial transaction is resumed.
REQ-016 After release, lcd_on_o SHALL be 1 from the first clock edge.

Structure
REQ-017 Package lcd_pkg SHALL hold the following:
- the state enum;
- init ROM constants: INIT_LEN=4 and the four bytes;
- CMD_CLEAR=0x01 and CMD_HOME=0x02.
REQ-018 No sub-module is required.
- The LSU/IO wrapper instantiates lcd_ctrl, replacing the software-driven bits of the io_lcd register.

Verification (sim with T_SETUP=2, T_EN_HIGH=3, T_HOLD=2, T_CMD_WAIT=5, T_CLR_WAIT=9, T_PWRUP=10)
REQ-019 Init: release reset; the bench SHALL observe the following:
- exactly 4 EN pulses carrying 0x38, 0x0C, 0x01, 0x06 with rs=0;
- a 9-cycle wait after 0x01 and 5-cycle waits after the others;
- init_done_o=1, then req_ready_o=1.
REQ-020 Data write: valid with rs=1, data 0x41 SHALL produce one EN pulse 3 cycles high with rs=1 and data=0x41.
- Data is stable 2 cycles before and 2 cycles after the pulse.
- req_ready_o returns after the 5-cycle wait.
REQ-021 Clear: command 0x01 then data 0x42 held valid SHALL give 9 wait cycles, then 0x42 accepted on the first IDLE cycle.
- Back-to-back command 0x80 then 0x80 SHALL give 5-cycle waits.
REQ-022 Early request: req_valid_i held high from reset release SHALL produce no accept until init_done_o=1.
- Data is unchanged by the early request.
REQ-023 Reset mid-EN_HI SHALL drop lcd_en_o in the same cycle, with no clock edge needed, and force all outputs to 0.
- After release, init replays from 0x38.
